// File: rtl/matmul_scheduler_pkg.sv
// Shared widths, FSM state encoding and the operand-pair record used by the
// matmul scheduler and its operand FIFO.
package matmul_pkg;

    localparam int MAX_ELEMENT_SIZE = 8;
    localparam int MAX_SIZE_A       = 32;
    localparam int MAX_SIZE_B       = 32;
    localparam int READ_LATENCY     = 3;
    localparam int FIFO_DEPTH       = READ_LATENCY + 1;

    localparam int ROW_W   = MAX_SIZE_A * MAX_ELEMENT_SIZE;
    localparam int IDX_A_W = $clog2(MAX_SIZE_A);
    localparam int IDX_B_W = $clog2(MAX_SIZE_B);
    localparam int CFG_A_W = IDX_A_W + 1;
    localparam int CFG_B_W = IDX_B_W + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        RUN       = 2'd2,
        DRAIN     = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [ROW_W-1:0]   row;
        logic [ROW_W-1:0]   col;
        logic [IDX_A_W-1:0] i;
        logic [IDX_B_W-1:0] j;
        logic               last;
    } dot_pair_t;

    function automatic logic [CFG_A_W-1:0] clamp_rows(input logic [CFG_A_W-1:0] v);
        logic [CFG_A_W-1:0] r;
        if (v == '0) begin
            r = CFG_A_W'(1);
        end else if (v > CFG_A_W'(MAX_SIZE_A)) begin
            r = CFG_A_W'(MAX_SIZE_A);
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [CFG_B_W-1:0] clamp_cols(input logic [CFG_B_W-1:0] v);
        logic [CFG_B_W-1:0] r;
        if (v == '0) begin
            r = CFG_B_W'(1);
        end else if (v > CFG_B_W'(MAX_SIZE_B)) begin
            r = CFG_B_W'(MAX_SIZE_B);
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/matmul_scheduler_if.sv
// Loader read port and dot-product dispatch handshake of the matmul scheduler.
interface matmul_scheduler_if;
    import matmul_pkg::*;

    logic               loader_complete;
    logic [IDX_A_W-1:0] requested_a_row;
    logic [IDX_B_W-1:0] requested_b_col;
    logic [IDX_A_W-1:0] a_addr_in;
    logic [IDX_B_W-1:0] b_addr_in;
    logic [ROW_W-1:0]   a_row_in;
    logic [ROW_W-1:0]   b_col_in;
    logic               dot_valid;
    logic               dot_ready;
    logic [ROW_W-1:0]   dot_a;
    logic [ROW_W-1:0]   dot_b;
    logic [IDX_A_W-1:0] dot_i;
    logic [IDX_B_W-1:0] dot_j;
    logic               dot_last;

    modport master (
        input  loader_complete, a_addr_in, b_addr_in, a_row_in, b_col_in, dot_ready,
        output requested_a_row, requested_b_col, dot_valid, dot_a, dot_b, dot_i, dot_j, dot_last
    );

    modport slave (
        output loader_complete, a_addr_in, b_addr_in, a_row_in, b_col_in, dot_ready,
        input  requested_a_row, requested_b_col, dot_valid, dot_a, dot_b, dot_i, dot_j, dot_last
    );

endinterface

// File: rtl/matmul_sched_fifo.sv
// Synchronous FIFO of operand pairs; the head comes straight from the storage
// registers so the dispatch outputs are flop-driven and stable while stalled.
module matmul_sched_fifo
    import matmul_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  dot_pair_t                    i_data,
    input  logic                         i_pop,
    output dot_pair_t                    o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dot_pair_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count != CW'(DEPTH)) || w_pop);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/matmul_scheduler.sv
// Walks the (i,j) output grid, issues credit-limited loader reads and streams the
// returned operand pairs to the dot engine. Optional MATMUL_SCHED_TAG_CHECK_EN checks return tags.
module matmul_scheduler
    import matmul_pkg::*;
(
    input  logic               inter_refclk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CFG_A_W-1:0] cfg_rows,
    input  logic [CFG_B_W-1:0] cfg_cols,
    matmul_scheduler_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               err
);
    sched_state_t            r_state;
    sched_state_t            w_state_next;
    logic [CFG_A_W-1:0]      r_rows;
    logic [CFG_B_W-1:0]      r_cols;
    logic [IDX_A_W-1:0]      r_i;
    logic [IDX_B_W-1:0]      r_j;
    logic [IDX_A_W-1:0]      r_req_a;
    logic [IDX_B_W-1:0]      r_req_b;
    logic [READ_LATENCY-1:0] r_sr_v;
    logic [READ_LATENCY-1:0] r_sr_last;
    logic [IDX_A_W-1:0]      r_sr_i [READ_LATENCY];
    logic [IDX_B_W-1:0]      r_sr_j [READ_LATENCY];
    logic                    r_busy;
    logic                    r_done;
    logic                    w_err;
    logic                    w_start_acc;
    logic                    w_finish;
    logic                    w_issue;
    logic                    w_j_wrap;
    logic                    w_last_coord;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_empty;
    logic                    w_credit_ok;
    logic [CNT_W-1:0]        w_inflight;
    logic [CNT_W-1:0]        w_count;
    logic [CNT_W:0]          w_used;
    logic [CNT_W:0]          w_room;
    dot_pair_t               w_head;
    dot_pair_t               w_push_data;

    // Number of reads still travelling through the loader.
    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < READ_LATENCY; k++) begin
            w_inflight = w_inflight + CNT_W'(r_sr_v[k]);
        end
    end

    // A slot freed by this cycle's pop may be reused by this cycle's issue, which
    // is what sustains one pair per cycle with only READ_LATENCY+1 entries.
    assign w_pop        = !w_empty && bus.dot_ready;
    assign w_used       = {1'b0, w_count} + {1'b0, w_inflight};
    assign w_room       = (CNT_W+1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, w_pop};
    assign w_credit_ok  = (w_room > w_used);
    assign w_issue      = (r_state == RUN) && w_credit_ok;
    assign w_j_wrap     = ({1'b0, r_j} == (r_cols - CFG_B_W'(1)));
    assign w_last_coord = w_j_wrap && ({1'b0, r_i} == (r_rows - CFG_A_W'(1)));
    assign w_push       = r_sr_v[READ_LATENCY-1];

    // Operand pair assembled from the loader return and the expected tag.
    always_comb begin
        w_push_data      = '0;
        w_push_data.row  = bus.a_row_in;
        w_push_data.col  = bus.b_col_in;
        w_push_data.i    = r_sr_i[READ_LATENCY-1];
        w_push_data.j    = r_sr_j[READ_LATENCY-1];
        w_push_data.last = r_sr_last[READ_LATENCY-1];
    end

    // Next-state logic and job start/finish strobes.
    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = WAIT_LOAD;
                    w_start_acc  = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (bus.loader_complete) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = WAIT_LOAD;
                end
            end
            RUN: begin
                if (w_issue && w_last_coord) begin
                    w_state_next = DRAIN;
                end else begin
                    w_state_next = RUN;
                end
            end
            DRAIN: begin
                if (w_pop && w_head.last && (w_inflight == '0)) begin
                    w_state_next = IDLE;
                    w_finish     = 1'b1;
                end else begin
                    w_state_next = DRAIN;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge inter_refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Job size, coordinate walk and read-address outputs.
    always_ff @(posedge inter_refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows  <= '0;
            r_cols  <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_req_a <= '0;
            r_req_b <= '0;
        end else if (w_start_acc) begin
            r_rows <= clamp_rows(cfg_rows);
            r_cols <= clamp_cols(cfg_cols);
            r_i    <= '0;
            r_j    <= '0;
        end else if (w_issue) begin
            r_req_a <= r_i;
            r_req_b <= r_j;
            if (w_j_wrap) begin
                r_j <= '0;
                r_i <= r_i + IDX_A_W'(1);
            end else begin
                r_j <= r_j + IDX_B_W'(1);
            end
        end
    end

    // Valid/tag pipeline matching the loader read latency.
    always_ff @(posedge inter_refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_v    <= '0;
            r_sr_last <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_sr_i[k] <= '0;
                r_sr_j[k] <= '0;
            end
        end else begin
            r_sr_v[0]    <= w_issue;
            r_sr_last[0] <= w_issue && w_last_coord;
            r_sr_i[0]    <= r_i;
            r_sr_j[0]    <= r_j;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_sr_v[k]    <= r_sr_v[k-1];
                r_sr_last[k] <= r_sr_last[k-1];
                r_sr_i[k]    <= r_sr_i[k-1];
                r_sr_j[k]    <= r_sr_j[k-1];
            end
        end
    end

    // Busy level and done pulse.
    always_ff @(posedge inter_refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_start_acc) begin
                r_busy <= 1'b1;
            end else if (w_finish) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
        end
    end

`ifdef MATMUL_SCHED_TAG_CHECK_EN
    logic r_err;
    logic w_tag_mismatch;

    assign w_tag_mismatch = w_push &&
                            ((bus.a_addr_in != r_sr_i[READ_LATENCY-1]) ||
                             (bus.b_addr_in != r_sr_j[READ_LATENCY-1]));

    // Sticky tag error, cleared when a new job is accepted.
    always_ff @(posedge inter_refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end else if (w_tag_mismatch) begin
            r_err <= 1'b1;
        end
    end

    assign w_err = r_err;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{bus.a_addr_in, bus.b_addr_in};
    assign w_err         = 1'b0;
`endif

    matmul_sched_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (inter_refclk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign bus.requested_a_row = r_req_a;
    assign bus.requested_b_col = r_req_b;
    assign bus.dot_valid       = !w_empty;
    assign bus.dot_a           = w_head.row;
    assign bus.dot_b           = w_head.col;
    assign bus.dot_i           = w_head.i;
    assign bus.dot_j           = w_head.j;
    assign bus.dot_last        = w_head.last;
    assign busy                = r_busy;
    assign done                = r_done;
    assign err                 = w_err;

endmodule
